// File: rtl/idma_axis_buf_pkg.sv
// Shared types and helpers for the iDMA AXI-Stream write packet buffer.
package idma_axis_buf_pkg;

  // STORE: store-and-forward, CUT: oversize packet forwarded as stored
  typedef enum logic {
    STORE = 1'b0,
    CUT   = 1'b1
  } buf_state_e;

  localparam int unsigned StatsBytesWidth = 64;
  localparam int unsigned StatsPktsWidth  = 32;
  // Widest tkeep the byte counter handles (DataWidth up to 1024 bits)
  localparam int unsigned MaxKeepWidth    = 128;

  // Number of valid bytes in a (zero-extended) tkeep mask
  function automatic logic [StatsBytesWidth-1:0] popcount_keep(input logic [MaxKeepWidth-1:0] keep);
    logic [StatsBytesWidth-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < MaxKeepWidth; i++) begin
      cnt = cnt + StatsBytesWidth'(keep[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/idma_axis_beat_fifo.sv
// Circular register FIFO holding {tlast, tkeep, tdata} beats.
// Pointers wrap modulo Depth (power of two); occ tracks fill level.
// Callers qualify push_i with !full_o and pop_i with !empty_o.
module idma_axis_beat_fifo
  import idma_axis_buf_pkg::*;
#(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = 16,
  parameter int unsigned KeepWidth = DataWidth / 8,
  parameter int unsigned CntWidth  = $clog2(Depth) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [KeepWidth-1:0] wkeep_i,
  input  logic                 wlast_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic [KeepWidth-1:0] rkeep_o,
  output logic                 rlast_o,
  output logic [CntWidth-1:0]  occ_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PtrWidth   = $clog2(Depth);
  localparam int unsigned EntryWidth = DataWidth + KeepWidth + 1;

  logic [EntryWidth-1:0] entry_q [Depth];
  logic [PtrWidth-1:0]   wptr_q, rptr_q;
  logic [CntWidth-1:0]   occ_q;

  for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
    // Capture the incoming beat in the slot addressed by the write pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        entry_q[gi] <= '0;
      end else if (push_i && !clear_i && (wptr_q == PtrWidth'(gi))) begin
        entry_q[gi] <= {wlast_i, wkeep_i, wdata_i};
      end
    end
  end

  // Pointer and occupancy bookkeeping; a flush overrides any push or pop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else if (clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PtrWidth'(1);
      if (pop_i)  rptr_q <= rptr_q + PtrWidth'(1);
      if (push_i && !pop_i) begin
        occ_q <= occ_q + CntWidth'(1);
      end else if (!push_i && pop_i) begin
        occ_q <= occ_q - CntWidth'(1);
      end
    end
  end

  assign {rlast_o, rkeep_o, rdata_o} = entry_q[rptr_q];
  assign occ_o   = occ_q;
  assign full_o  = (occ_q == CntWidth'(Depth));
  assign empty_o = (occ_q == '0);

endmodule

// File: rtl/idma_axis_wr_pkt_buffer.sv
// Store-and-forward AXI-Stream packet buffer with cut-through fallback for
// packets larger than the storage. Optional statistics outputs are enabled
// by defining IDMA_AXIS_PKT_STATS_EN.
module idma_axis_wr_pkt_buffer
  import idma_axis_buf_pkg::*;
#(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = 16,
  parameter int unsigned KeepWidth = DataWidth / 8,
  parameter int unsigned CntWidth  = $clog2(Depth) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataWidth-1:0] s_tdata_i,
  input  logic [KeepWidth-1:0] s_tkeep_i,
  input  logic                 s_tlast_i,
  input  logic                 s_tvalid_i,
  output logic                 s_tready_o,
  output logic [DataWidth-1:0] m_tdata_o,
  output logic [KeepWidth-1:0] m_tkeep_o,
  output logic                 m_tlast_o,
  output logic                 m_tvalid_o,
  input  logic                 m_tready_i,
  input  logic                 clear_i,
  output logic [CntWidth-1:0]  pkt_count_o,
  output logic                 oversize_o
`ifdef IDMA_AXIS_PKT_STATS_EN
  ,
  output logic [StatsBytesWidth-1:0] stat_bytes_o,
  output logic [StatsPktsWidth-1:0]  stat_pkts_o
`endif
);

  buf_state_e          state_q, state_d;
  logic [CntWidth-1:0] pkt_cnt_q;
  logic [CntWidth-1:0] occ;
  logic                full, empty;
  logic                push, pop;

  // Ready never looks at the downstream side, so the last slot is never
  // handed to a push on the strength of a same-cycle pop.
  assign s_tready_o = !full;
  assign push       = s_tvalid_i && s_tready_o;
  assign m_tvalid_o = !empty && ((pkt_cnt_q != '0) || (state_q == CUT));
  assign pop        = m_tvalid_o && m_tready_i;

  idma_axis_beat_fifo #(
    .DataWidth (DataWidth),
    .Depth     (Depth),
    .KeepWidth (KeepWidth),
    .CntWidth  (CntWidth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (push),
    .wdata_i (s_tdata_i),
    .wkeep_i (s_tkeep_i),
    .wlast_i (s_tlast_i),
    .pop_i   (pop),
    .rdata_o (m_tdata_o),
    .rkeep_o (m_tkeep_o),
    .rlast_o (m_tlast_o),
    .occ_o   (occ),
    .full_o  (full),
    .empty_o (empty)
  );

  // Count complete packets held: tlast in adds one, tlast out removes one
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pkt_cnt_q <= '0;
    end else if (clear_i) begin
      pkt_cnt_q <= '0;
    end else if ((push && s_tlast_i) && !(pop && m_tlast_o)) begin
      pkt_cnt_q <= pkt_cnt_q + CntWidth'(1);
    end else if (!(push && s_tlast_i) && (pop && m_tlast_o)) begin
      pkt_cnt_q <= pkt_cnt_q - CntWidth'(1);
    end
  end

  assign pkt_count_o = pkt_cnt_q;

  // Mode state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= STORE;
    end else begin
      state_q <= state_d;
    end
  end

  // Full with no complete packet means the packet cannot fit: forward it as
  // it arrives until its tlast beat leaves
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = STORE;
    end else begin
      unique case (state_q)
        STORE: if (full && (pkt_cnt_q == '0)) state_d = CUT;
        CUT:   if (pop && m_tlast_o)          state_d = STORE;
        default: state_d = STORE;
      endcase
    end
  end

  // Oversize flag is high in the single cycle that commits the switch to CUT
  always_comb begin
    oversize_o = 1'b0;
    if (!clear_i && (state_q == STORE) && full && (pkt_cnt_q == '0)) begin
      oversize_o = 1'b1;
    end
  end

`ifdef IDMA_AXIS_PKT_STATS_EN
  logic [StatsBytesWidth-1:0] stat_bytes_q;
  logic [StatsPktsWidth-1:0]  stat_pkts_q;

  // Running byte and packet totals over delivered beats; survive a flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_bytes_q <= '0;
      stat_pkts_q  <= '0;
    end else if (pop && !clear_i) begin
      stat_bytes_q <= stat_bytes_q + popcount_keep(MaxKeepWidth'(m_tkeep_o));
      if (m_tlast_o) stat_pkts_q <= stat_pkts_q + StatsPktsWidth'(1);
    end
  end

  assign stat_bytes_o = stat_bytes_q;
  assign stat_pkts_o  = stat_pkts_q;
`else
  // Occupancy is only consumed inside the FIFO in this build
  logic unused_occ;
  assign unused_occ = ^occ;
`endif

endmodule

// File: doc/idma_axis_wr_pkt_buffer.md
Name: idma_axis_wr_pkt_buffer

Overview:
- Store-and-forward AXI-Stream packet buffer between the iDMA backend's AXI-Stream write port and the downstream stream consumer (e.g. a NIC or accelerator).
- Holds beats until a full packet (`tlast`) is stored, then releases it back-to-back, so the consumer never sees mid-packet bubbles caused by backend read stalls.
- Packets longer than the buffer fall back to cut-through, so the block cannot deadlock.

Parameters:
- DataWidth, 64, stream data width in bits; multiple of 8.
- Depth, 16, beat storage entries; power of two, at least 2.
- KeepWidth, DataWidth/8, `tkeep` width (do not override).
- CntWidth, $clog2(Depth)+1, width of the occupancy and stored-packet counters (do not override).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; one clock; asynchronous, active-high.
- s_tdata_i  input  DataWidth  upstream beat data.
- s_tkeep_i  input  KeepWidth  upstream byte-valid mask.
- s_tlast_i  input  1  last beat of packet.
- s_tvalid_i  input  1  upstream valid.
- s_tready_o  output  1  buffer can accept a beat.
- m_tdata_o  output  DataWidth  downstream beat data.
- m_tkeep_o  output  KeepWidth  downstream byte mask.
- m_tlast_o  output  1  downstream last.
- m_tvalid_o  output  1  downstream valid.
- m_tready_i  input  1  downstream ready.
- clear_i  input  1  synchronous flush of all stored beats; only legal while the upstream is idle.
- pkt_count_o  output  CntWidth  number of complete packets currently stored.
- oversize_o  output  1  one-cycle pulse when cut-through mode is entered.

Behaviour:
- Reset values: all outputs 0, pointers 0, counters 0, state STORE.
- Storage is a circular register FIFO with read/write pointers of $clog2(Depth) bits that wrap modulo Depth, plus an occupancy counter `occ`.
  - full: occ==Depth.
  - empty: occ==0.
- Upstream side:
  - s_tready_o = !full; it does not depend on m_tready_i, so a pop and a push cannot share the last slot in the same cycle.
  - Push when s_tvalid_i && s_tready_o; tdata, tkeep and tlast are written at the write pointer.
- Downstream side:
  - m_* are driven combinationally from the read-pointer entry.
  - m_tvalid_o = !empty && (pkt_count_o!=0 || state==CUT).
  - Pop when m_tvalid_o && m_tready_i.
  - The AXI-Stream rule holds: once m_tvalid_o rises it stays high until the handshake, and data is stable while held.
- Latency: a beat pushed in cycle N is visible at m_* in cycle N+1 at the earliest, and only once its packet's tlast beat has been pushed or state==CUT.
- pkt_count_o:
  - +1 on a push with tlast.
  - −1 on a pop with tlast.
  - Unchanged when both happen in the same cycle.
- State machine:
  - STORE: normal store-and-forward. If full && pkt_count_o==0, the stored beats form an incomplete packet larger than Depth; go to CUT and pulse oversize_o for one cycle.
  - CUT: beats are forwarded as soon as stored. Return to STORE on the pop of a beat with tlast. A push with tlast in CUT also increments pkt_count_o; that count is decremented by the matching pop.
- clear_i:
  - Resets pointers, occ, pkt_count_o and state to STORE on the next edge.
  - Has priority over a push or pop in the same cycle; m_tvalid_o deasserts the following cycle.
- Reset asserted mid-packet discards all buffered beats immediately (asynchronous), with no partial output afterwards.

Optional Feature:
- Macro IDMA_AXIS_PKT_STATS_EN.
- When defined, two outputs are added:
  - stat_bytes_o (64 bits): wrapping sum of popcount(m_tkeep_o) over all pops.
  - stat_pkts_o (32 bits): wrapping count of tlast pops.
  - Both reset to 0 on rst_i; clear_i does not clear them.
- When undefined, these ports and registers do not exist and the rest of the behaviour is identical.

Decomposition:
- Shared package idma_axis_buf_pkg:
  - typedef buf_state_e {STORE, CUT}.
  - Function popcount_keep.
  - Constant StatsBytesWidth=64.
- One sub-module: idma_axis_beat_fifo, holding the storage array, pointers and occ.
- The packet counter, state machine and statistics stay in the top.

Test Plan:
- Single 4-beat packet, all tkeep set, downstream ready → m_tvalid_o stays 0 until the tlast push; the 4 beats appear on 4 consecutive cycles starting 1 cycle after the tlast push; pkt_count_o goes 1→0.
- Two 3-beat packets pushed with m_tready_i=0 → pkt_count_o=2 and occ=6. Raise ready → 6 contiguous beats in order, tlast on beats 3 and 6.
- Depth=16, 20-beat packet, ready low → s_tready_o drops after 16 beats and oversize_o pulses once. Raise ready → beats stream in cut-through; state returns to STORE after the beat-20 pop.
- Same-cycle tlast push and tlast pop with pkt_count_o=1 → pkt_count_o remains 1.
- clear_i with 5 beats stored → next cycle occ=0, m_tvalid_o=0, pkt_count_o=0. A subsequent 2-beat packet passes correctly.
- With IDMA_AXIS_PKT_STATS_EN: packet with tkeep 0xFF, 0xFF, 0x0F → stat_bytes_o=20, stat_pkts_o=1.
